// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and sequencer for the external multiplier and iterative divider.
// Latency: MFHI/MFLO return in the accept cycle; HI/LO update MUL_LAT cycles after a MULT is
// accepted, and on div_complete for a DIV. issue_ready drops while MUL/DIV is in flight.
// Optional feature macro MULDIV_BYPASS_EN: lets MFHI/MFLO complete in the completion cycle.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_op,
  input  logic        issue_signed,
  input  logic [31:0] issue_x,
  input  logic [31:0] issue_y,
  output logic        issue_ready,
  output logic [31:0] rd_data,
  input  logic        flush,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_res,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_cancel,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_mul_done;
  logic        w_div_done;
  logic        w_complete;
  logic        w_is_mf;
  logic        w_accept;
  logic        w_y_zero;
  logic [31:0] w_fwd_hi;
  logic [31:0] w_fwd_lo;

  // Operands go straight through; the multiplier/divider capture them on accept.
  assign mul_signed = issue_signed;
  assign mul_x      = issue_x;
  assign mul_y      = issue_y;
  assign div_signed = issue_signed;
  assign div_x      = issue_x;
  assign div_y      = issue_y;

  assign hi_o = r_hi;
  assign lo_o = r_lo;
  assign busy = (r_state != S_IDLE);

  assign w_idle     = (r_state == S_IDLE);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == 3'd0);
  assign w_div_done = (r_state == S_DIV) && div_complete;
  // A flush in the completion cycle kills the result, so it is not a completion.
  assign w_complete = (w_mul_done || w_div_done) && !flush;
  assign w_is_mf    = (issue_op == OP_MFHI) || (issue_op == OP_MFLO);
  assign w_y_zero   = (issue_y == 32'd0);

  // Value the in-flight op is about to commit, used for forwarding in the completion cycle.
  assign w_fwd_hi = (r_state == S_MUL) ? mul_res[63:32] : div_r;
  assign w_fwd_lo = (r_state == S_MUL) ? mul_res[31:0]  : div_s;

  // Ready: always in IDLE; optionally for MFHI/MFLO while the result is being committed.
  always_comb begin
    issue_ready = w_idle;
`ifdef MULDIV_BYPASS_EN
    if (w_complete && w_is_mf) begin
      issue_ready = 1'b1;
    end
`endif
  end

  assign w_accept = issue_valid && issue_ready && !flush;

  // Divider start only for a real divide; divide-by-zero is a silent no-op.
  assign div_start  = w_accept && w_idle && (issue_op == OP_DIV) && !w_y_zero;
  // Cancel the divider on flush; reset is shared so it needs no cancel.
  assign div_cancel = (r_state == S_DIV) && flush;

  // MFHI/MFLO read data, zero outside an accepted move-from.
  always_comb begin
    rd_data = 32'd0;
    if (w_accept && w_is_mf) begin
      if (w_idle) begin
        rd_data = (issue_op == OP_MFHI) ? r_hi : r_lo;
      end else begin
        rd_data = (issue_op == OP_MFHI) ? w_fwd_hi : w_fwd_lo;
      end
    end
  end

  // Sequencer state, multiplier latency counter and HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (issue_op)
              OP_MULT: begin
                r_state <= S_MUL;
                r_cnt   <= CNT_INIT;
              end
              OP_DIV: begin
                if (!w_y_zero) begin
                  r_state <= S_DIV;
                end
              end
              OP_MTHI: r_hi <= issue_x;
              OP_MTLO: r_lo <= issue_x;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt == 3'd0) begin
            r_hi    <= mul_res[63:32];
            r_lo    <= mul_res[31:0];
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (div_complete) begin
            r_hi    <= div_r;
            r_lo    <= div_s;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl with behavioural multiplier and divider models.
// Multiplier: 2-stage pipeline. Divider: completes 33 cycles after div_start.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic        issue_signed;
  logic [31:0] issue_x;
  logic [31:0] issue_y;
  logic        issue_ready;
  logic [31:0] rd_data;
  logic        flush;
  logic        busy;
  logic        mul_signed;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_res;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_cancel;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_vec;
  int n_err;

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_signed(issue_signed),
    .issue_x(issue_x), .issue_y(issue_y), .issue_ready(issue_ready), .rd_data(rd_data),
    .flush(flush), .busy(busy),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_res(mul_res),
    .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_cancel(div_cancel), .div_s(div_s), .div_r(div_r), .div_complete(div_complete),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product of the operands presented two edges earlier.
  logic [63:0] m_p1, m_p2;
  logic [63:0] m_ex, m_ey;
  always_comb begin
    m_ex = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'd0, mul_x};
    m_ey = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'd0, mul_y};
  end
  always @(posedge clk) begin
    m_p1 <= m_ex * m_ey;
    m_p2 <= m_p1;
  end
  assign mul_res = m_p2;

  // Divider model: result pulse 33 cycles after start; cancel/reset abort it.
  int          d_cnt;
  logic [31:0] d_q, d_r;
  logic        stray_cmp;
  always @(posedge clk) begin
    if (reset || div_cancel) begin
      d_cnt <= 0;
    end else if (div_start) begin
      d_cnt <= 33;
      if (div_signed) begin
        d_q <= $signed(div_x) / $signed(div_y);
        d_r <= $signed(div_x) % $signed(div_y);
      end else begin
        d_q <= div_x / div_y;
        d_r <= div_x % div_y;
      end
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
    end
  end
  assign div_complete = (d_cnt == 1) || stray_cmp;
  assign div_s = d_q;
  assign div_r = d_r;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic sgn, input logic [31:0] x, input logic [31:0] y);
    issue_valid  = 1'b1;
    issue_op     = op;
    issue_signed = sgn;
    issue_x      = x;
    issue_y      = y;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    #1;
    n_vec++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi_o); end
    n_vec++; if (lo_o !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo_o); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    n_vec++; if ({div_start, div_cancel} !== 2'b00) begin n_err++; $display("FAIL reset_div got %b want 00", {div_start, div_cancel}); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd got %h want 0", rd_data); end
  endtask

  task automatic test_mult;
    tick;
    issue(3'd0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL mult_accept got %b want 1", issue_ready); end
    tick;
    issue_valid = 1'b0;
    #1;
    n_vec++; if ({issue_ready, busy} !== 2'b01) begin n_err++; $display("FAIL mult_stall1 got %b want 01", {issue_ready, busy}); end
    tick; #1;
    n_vec++; if ({issue_ready, busy} !== 2'b01) begin n_err++; $display("FAIL mult_stall2 got %b want 01", {issue_ready, busy}); end
    tick;
    issue(3'd4, 1'b0, 32'd0, 32'd0);
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL mult_ready_after got %b want 1", issue_ready); end
    n_vec++; if (hi_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
    n_vec++; if (lo_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo got %h want fffffffe", lo_o); end
    n_vec++; if (rd_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_mfhi got %h want ffffffff", rd_data); end
    tick;
    issue_valid = 1'b0;
    #1;
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL rd_idle got %h want 0", rd_data); end
  endtask

  task automatic test_div;
    int acc, bc, ds;
    logic [31:0] rdv;
    acc = -1; bc = 0; ds = 0; rdv = 32'd0;
    issue(3'd1, 1'b0, 32'd100, 32'd7);
    #1;
    n_vec++; if (div_start !== 1'b1) begin n_err++; $display("FAIL div_start got %b want 1", div_start); end
    tick;
    issue_op = 3'd5;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (div_start) ds++;
      if (busy) bc++;
      if (issue_ready) begin
        acc = c;
        rdv = rd_data;
        break;
      end
      tick;
    end
    tick;
    issue_valid = 1'b0;
    #1;
`ifdef MULDIV_BYPASS_EN
    n_vec++; if (acc !== 33) begin n_err++; $display("FAIL div_mflo_cycle got %0d want 33", acc); end
`else
    n_vec++; if (acc !== 34) begin n_err++; $display("FAIL div_mflo_cycle got %0d want 34", acc); end
`endif
    n_vec++; if (rdv !== 32'd14) begin n_err++; $display("FAIL div_mflo_data got %0d want 14", rdv); end
    n_vec++; if (bc !== 33) begin n_err++; $display("FAIL div_busy_cycles got %0d want 33", bc); end
    n_vec++; if (ds !== 0) begin n_err++; $display("FAIL div_start_pulse extra pulses %0d want 0", ds); end
    n_vec++; if (lo_o !== 32'd14) begin n_err++; $display("FAIL div_lo got %0d want 14", lo_o); end
    n_vec++; if (hi_o !== 32'd2) begin n_err++; $display("FAIL div_hi got %0d want 2", hi_o); end
  endtask

  task automatic test_div_zero;
    issue(3'd2, 1'b0, 32'h11, 32'd0);
    tick;
    issue(3'd3, 1'b0, 32'h22, 32'd0);
    tick;
    issue(3'd1, 1'b1, 32'hFFFF_FFF9, 32'd0);
    #1;
    n_vec++; if (div_start !== 1'b0) begin n_err++; $display("FAIL div0_start got %b want 0", div_start); end
    tick;
    issue_valid = 1'b0;
    #1;
    n_vec++; if ({issue_ready, busy} !== 2'b10) begin n_err++; $display("FAIL div0_ready got %b want 10", {issue_ready, busy}); end
    n_vec++; if ({hi_o, lo_o} !== {32'h11, 32'h22}) begin n_err++; $display("FAIL div0_hilo got %h want 0000001100000022", {hi_o, lo_o}); end
  endtask

  task automatic test_mt_mf;
    issue(3'd2, 1'b0, 32'hDEAD_BEEF, 32'd0);
    tick;
    issue(3'd4, 1'b0, 32'd0, 32'd0);
    #1;
    n_vec++; if (rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mthi_mfhi got %h want deadbeef", rd_data); end
    tick;
    issue(3'd3, 1'b0, 32'h5, 32'd0);
    flush = 1'b1;
    tick;
    issue_valid = 1'b0;
    flush = 1'b0;
    #1;
    n_vec++; if (lo_o !== 32'h22) begin n_err++; $display("FAIL mtlo_flush got %h want 22", lo_o); end
  endtask

  task automatic test_div_flush;
    int nc;
    nc = 0;
    issue(3'd1, 1'b0, 32'd100, 32'd7);
    tick;
    issue_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      #1; if (div_cancel) nc++;
      tick;
    end
    flush = 1'b1;
    #1; if (div_cancel) nc++;
    tick;
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; if (div_cancel) nc++;
      if (c == 0) begin
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL divflush_idle busy got %b want 0", busy); end
      end
      tick;
    end
    n_vec++; if (nc !== 1) begin n_err++; $display("FAIL divflush_cancel pulses got %0d want 1", nc); end
    stray_cmp = 1'b1;
    tick;
    stray_cmp = 1'b0;
    #1;
    n_vec++; if ({hi_o, lo_o} !== {32'hDEAD_BEEF, 32'h22}) begin n_err++; $display("FAIL divflush_hilo got %h want deadbeef00000022", {hi_o, lo_o}); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_busy got %b want 0", busy); end
  endtask

  task automatic test_mul_flush;
    issue(3'd0, 1'b0, 32'd3, 32'd5);
    tick;
    issue_valid = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    n_vec++; if ({busy, issue_ready} !== 2'b01) begin n_err++; $display("FAIL mulflush_state got %b want 01", {busy, issue_ready}); end
    n_vec++; if ({hi_o, lo_o} !== {32'hDEAD_BEEF, 32'h22}) begin n_err++; $display("FAIL mulflush_hilo got %h want deadbeef00000022", {hi_o, lo_o}); end
  endtask

  task automatic test_reset_mid_div;
    logic cseen;
    issue(3'd1, 1'b0, 32'd100, 32'd7);
    tick;
    issue_valid = 1'b0;
    tick; tick; tick;
    reset = 1'b1;
    #1;
    cseen = div_cancel;
    tick;
    reset = 1'b0;
    #1;
    n_vec++; if (cseen !== 1'b0) begin n_err++; $display("FAIL rstdiv_cancel got %b want 0", cseen); end
    n_vec++; if ({hi_o, lo_o} !== 64'd0) begin n_err++; $display("FAIL rstdiv_hilo got %h want 0", {hi_o, lo_o}); end
    n_vec++; if ({busy, issue_ready} !== 2'b01) begin n_err++; $display("FAIL rstdiv_state got %b want 01", {busy, issue_ready}); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; issue_valid = 1'b0; issue_op = 3'd0; issue_signed = 1'b0;
    issue_x = 32'd0; issue_y = 32'd0; flush = 1'b0; stray_cmp = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_mt_mf;
    test_div_flush;
    test_mul_flush;
    test_reset_mid_div;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
